// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the boot-time program loader:
//   - loader_state_t : loader FSM state encoding
//   - HDR_BYTES      : number of length-header bytes in front of the payload
//   - WORD_BYTES     : bytes per instruction word (big-endian assembly)
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHK    = 3'd3,
    ST_DONE   = 3'd4
  } loader_state_t;

endpackage : prog_loader_pkg

// File: rtl/prog_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// 8-to-32 big-endian shift register. The first byte of a word lands in bits
// 31:24. word_valid is asserted combinationally in the same cycle as the 4th
// accepted byte, with word already containing that byte, so the parent can
// register the write one cycle after the handshake.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   byte_valid  : accept byte_data this cycle
//   byte_data   : incoming stream byte
//   word_valid  : this byte completes a word
//   word        : assembled word (meaningful while word_valid)
// -----------------------------------------------------------------------------
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shreg;   // the three most recent bytes of the current word
  logic [1:0]  cnt;     // bytes already held for the current word

  assign word       = {shreg, byte_data};
  assign word_valid = byte_valid && (cnt == 2'(WORD_BYTES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_valid) begin
      shreg <= {shreg[15:0], byte_data};
      cnt   <= cnt + 2'd1;   // wraps to 0 after the 4th byte
    end
  end

endmodule : word_assembler

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Boot-time program loader. Consumes a byte stream of
//   len[15:8], len[7:0], len*4 data bytes (big-endian words), xor checksum
// and writes each word into instruction memory one cycle after its 4th byte.
// The cpu is held in reset until the load ends with a good checksum and no
// overflow.
//
// Parameters:
//   ADDR_W      : width of mem_addr (byte address)
//   BASE_ADDR   : byte address of the first word (word aligned)
//   DEPTH_WORDS : instruction memory capacity in words
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid    : stream byte and its valid
//   in_ready            : loader can accept a byte (0 only in reset and DONE)
//   mem_we/addr/wdata   : single instruction-memory write port
//   done                : sticky, load finished (checksum consumed)
//   err                 : sticky, checksum mismatch or length overflow
//   cpu_rst_n           : cpu reset release, 1 only when done && !err
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 0,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  localparam logic [31:0]       DEPTH_U = 32'(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);

  loader_state_t state;
  logic [15:0]   len;
  logic [16:0]   idx;   // 17 bits so it cannot wrap before reaching len
  logic [7:0]    chk;   // running xor over data bytes only

  logic              fire;
  logic              data_fire;
  logic              word_valid;
  logic [31:0]       word;
  logic [ADDR_W-1:0] wr_addr;
  logic              in_range;
  logic              last_word;
  logic              chk_bad;

  assign fire      = in_valid && in_ready;
  assign data_fire = fire && (state == ST_DATA);

  // Byte address of the word being completed, truncated to ADDR_W.
  assign wr_addr   = BASE_A + ADDR_W'({idx, 2'b00});
  assign in_range  = 32'(idx) < DEPTH_U;
  assign last_word = (idx + 17'd1) == {1'b0, len};
  assign chk_bad   = (in_data != chk);

  word_assembler u_word_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (data_fire),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LEN_HI;
      len       <= '0;
      idx       <= '0;
      chk       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_A;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; ready follows the state and is
      // dropped explicitly on the transition into DONE below.
      mem_we   <= 1'b0;
      in_ready <= (state != ST_DONE);

      unique case (state)
        ST_LEN_HI: begin
          if (fire) begin
            len[15:8] <= in_data;
            state     <= ST_LEN_LO;
          end
        end

        ST_LEN_LO: begin
          if (fire) begin
            len[7:0] <= in_data;
            state    <= ({len[15:8], in_data} == 16'd0) ? ST_CHK : ST_DATA;
          end
        end

        ST_DATA: begin
          if (fire) begin
            chk <= chk ^ in_data;
            if (word_valid) begin
              // Overflowing words are consumed so the stream stays framed,
              // but never reach the memory.
              if (in_range) begin
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= word;
              end else begin
                err <= 1'b1;
              end
              idx <= idx + 17'd1;
              if (last_word) state <= ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (fire) begin
            state     <= ST_DONE;
            in_ready  <= 1'b0;
            done      <= 1'b1;
            err       <= err | chk_bad;
            cpu_rst_n <= !(err | chk_bad);
          end
        end

        ST_DONE: begin
          in_ready <= 1'b0;
        end

        default: state <= ST_LEN_HI;
      endcase
    end
  end

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader. Two instances share the stimulus: u_dut with
// default parameters and u_ovf with DEPTH_WORDS=1 to exercise overflow.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready, mem_we, done, err, cpu_rst_n;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;

  logic        o_in_ready, o_mem_we, o_done, o_err, o_cpu_rst_n;
  logic [11:0] o_mem_addr;
  logic [31:0] o_mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prog_loader u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err),
    .cpu_rst_n (cpu_rst_n)
  );

  prog_loader #(.DEPTH_WORDS(1)) u_ovf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (o_in_ready),
    .mem_we    (o_mem_we),
    .mem_addr  (o_mem_addr),
    .mem_wdata (o_mem_wdata),
    .done      (o_done),
    .err       (o_err),
    .cpu_rst_n (o_cpu_rst_n)
  );

  // Write monitors: record every write seen on a falling edge.
  int          wr_n;
  logic [31:0] wr_addr_q [8];
  logic [31:0] wr_data_q [8];
  int          owr_n;
  logic [31:0] owr_addr_q [8];
  logic [31:0] owr_data_q [8];

  always @(negedge clk) begin
    if (!rst_n) wr_n = 0;
    else if (mem_we) begin
      if (wr_n < 8) begin
        wr_addr_q[wr_n] = 32'(mem_addr);
        wr_data_q[wr_n] = mem_wdata;
      end
      wr_n++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) owr_n = 0;
    else if (o_mem_we) begin
      if (owr_n < 8) begin
        owr_addr_q[owr_n] = 32'(o_mem_addr);
        owr_data_q[owr_n] = o_mem_wdata;
      end
      owr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] strm [11];

  // Called at a falling edge; returns at the falling edge after the handshake,
  // where the write strobe caused by this byte (if any) must be visible.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_we);
    int n;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("gap_we", 32'(mem_we), 32'd0);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("byte_we", 32'(mem_we), 32'(exp_we));
  endtask

  task automatic play(input int n, input int len, input bit gaps);
    bit ew;
    for (int i = 0; i < n; i++) begin
      ew = (i >= 2) && (i < 2 + 4 * len) && (((i - 2) % 4) == 3);
      send_byte(strm[i], gaps ? int'($urandom_range(3)) : 0, ew);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_in_ready"},  32'(in_ready),  32'd0);
    check({pfx, "_mem_we"},    32'(mem_we),    32'd0);
    check({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({pfx, "_mem_wdata"}, mem_wdata,      32'd0);
    check({pfx, "_done"},      32'(done),      32'd0);
    check({pfx, "_err"},       32'(err),       32'd0);
    check({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_flags(input string pfx, input bit e_done, input bit e_err, input bit e_cpu);
    check({pfx, "_done"},      32'(done),      32'(e_done));
    check({pfx, "_err"},       32'(err),       32'(e_err));
    check({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(e_cpu));
    check({pfx, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  task automatic check_two_writes(input string pfx);
    check({pfx, "_wr_n"}, 32'(wr_n), 32'd2);
    check({pfx, "_wr0_addr"}, wr_addr_q[0], 32'h0000_0000);
    check({pfx, "_wr0_data"}, wr_data_q[0], 32'h2002_0005);
    check({pfx, "_wr1_addr"}, wr_addr_q[1], 32'h0000_0004);
    check({pfx, "_wr1_data"}, wr_data_q[1], 32'h0000_000C);
  endtask

  task automatic load_scn1(input logic [7:0] chk_byte);
    strm = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h0C, chk_byte};
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);

    // Scenario 1: two words, good checksum (0x2B).
    do_reset();
    load_scn1(8'h2B);
    play(11, 2, 1'b0);
    check_flags("s1", 1'b1, 1'b0, 1'b1);
    check_two_writes("s1");
    // Overflow instance (DEPTH_WORDS=1) saw the same stream.
    check("ovf_wr_n",      32'(owr_n),      32'd1);
    check("ovf_wr0_addr",  owr_addr_q[0],   32'h0000_0000);
    check("ovf_wr0_data",  owr_data_q[0],   32'h2002_0005);
    check("ovf_done",      32'(o_done),     32'd1);
    check("ovf_err",       32'(o_err),      32'd1);
    check("ovf_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
    // DONE ignores further input.
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("done_idle_we", 32'(mem_we), 32'd0);
    end
    in_valid = 1'b0;
    check_flags("s1_idle", 1'b1, 1'b0, 1'b1);
    check("s1_idle_wr_n", 32'(wr_n), 32'd2);

    // Scenario 2: zero-length program.
    do_reset();
    strm = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    play(3, 0, 1'b0);
    check_flags("s2", 1'b1, 1'b0, 1'b1);
    check("s2_wr_n", 32'(wr_n), 32'd0);

    // Scenario 3: bad checksum.
    do_reset();
    load_scn1(8'hFF);
    play(11, 2, 1'b0);
    check_flags("s3", 1'b1, 1'b1, 1'b0);
    check_two_writes("s3");

    // Scenario 4: random in_valid gaps.
    do_reset();
    load_scn1(8'h2B);
    play(11, 2, 1'b1);
    check_flags("s4", 1'b1, 1'b0, 1'b1);
    check_two_writes("s4");

    // Scenario 5: reset mid-load after the 2nd data byte, then a clean load.
    do_reset();
    load_scn1(8'h2B);
    play(4, 2, 1'b0);
    check("s5_pre_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("s5_abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    play(11, 2, 1'b0);
    check_flags("s5", 1'b1, 1'b0, 1'b1);
    check_two_writes("s5");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_prog_loader

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader upstream of the single-cycle cpu. Accepts a byte stream: a 16-bit word count, the instruction words, then an XOR checksum byte. Assembles big-endian 32-bit words and writes them into instruction memory through a single write port. Holds the cpu in reset until the load completes with a good checksum.

Parameters:
ADDR_W, 12, width of mem_addr (byte address).
BASE_ADDR, 0, byte address of the first written word (word aligned).
DEPTH_WORDS, 1024, instruction memory capacity in words.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  8  stream byte.
in_valid  in  1  in_data is valid.
in_ready  out  1  loader accepts the byte; a transfer occurs when in_valid && in_ready.
mem_we  out  1  instruction memory write strobe, one cycle per word.
mem_addr  out  ADDR_W  byte address of the write.
mem_wdata  out  32  word to write.
done  out  1  load finished (checksum byte consumed), sticky.
err  out  1  checksum mismatch or length overflow, sticky.
cpu_rst_n  out  1  cpu reset release; 1 only when done && !err.

Behaviour:
- Reset (async, rst_n=0): state=LEN_HI; in_ready=0; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; done=0; err=0; cpu_rst_n=0. Byte counter, word index, length, and checksum are all cleared. Reset asserted mid-load aborts immediately. A partially written memory is not cleaned up.
- in_ready=1 in LEN_HI, LEN_LO, DATA and CHK. in_ready=0 in DONE. No backpressure is applied otherwise.
- LEN_HI: on transfer, len[15:8]=byte, go to LEN_LO.
- LEN_LO: on transfer, len[7:0]=byte. If the full len==0, go to CHK; else go to DATA.
- DATA: each transfer shifts the byte into the word assembler (first byte to bits 31:24) and XORs it into chk.
  - On the 4th byte of a word: the next cycle has mem_we=1, mem_wdata=the assembled word, and mem_addr=BASE_ADDR + 4*idx (truncated to ADDR_W). idx then increments.
  - Write latency is 1 cycle after the 4th handshake, with exactly one mem_we pulse per word.
  - After word len-1 is assembled, go to CHK. The last write is still issued in the following cycle.
- Overflow: words with idx >= DEPTH_WORDS are consumed but not written (mem_we stays 0), and err is set.
- CHK: on transfer, if the byte != chk, set err. Go to DONE.
- DONE: done=1 and cpu_rst_n=(err==0), registered and asserted on the cycle after the CHK transfer. The loader stays in DONE until reset, and further in_valid is ignored.
- Gaps: in_valid=0 cycles stall any state with no side effects. A byte is captured only on a handshake.
- Width rules:
  - len is 16 bits unsigned, maximum 65535 words.
  - idx is 17 bits internally so it never wraps before len.
  - chk is 8-bit XOR over data bytes only; the length bytes are excluded.

Decomposition:
- Shared package: state encoding (LEN_HI, LEN_LO, DATA, CHK, DONE), localparams for header length (2) and bytes per word (4).
- One natural sub-module: word_assembler, an 8-to-32 big-endian shift register with a 2-bit byte counter that outputs word_valid on the 4th byte.

Test Plan:
- Stream 00 02 | 20 02 00 05 | 00 00 00 0C | chk=0x2B (20^02^00^05^00^00^00^0C) -> two writes (addr 0, 0x20020005) and (addr 4, 0x0000000C), each one cycle after its 4th byte. done=1, err=0, cpu_rst_n=1.
- Stream 00 00 | 00 -> no mem_we. done=1, err=0, cpu_rst_n=1.
- Same as the first scenario but chk=0xFF -> both writes occur, done=1, err=1, cpu_rst_n=0.
- First scenario stream with random in_valid gaps of 0-3 cycles -> identical writes and final flags. No write during gaps.
- DEPTH_WORDS=1, len=2, correct chk -> only addr 0 written, err=1, cpu_rst_n=0.
- Assert rst_n=0 after the 2nd data byte, then replay the first scenario -> outputs reset asynchronously, then a clean load with done=1, cpu_rst_n=1.
